// File: rtl/regfile_write_scheduler_pkg.sv
// Shared widths and grant encodings for the register-bank write scheduler.
// Widths mirror the existing instruction-register and data-bus sizes.
package regfile_write_scheduler_pkg;

  localparam int INSTRUCTION_REGISTER_WIDTH = 5;
  localparam int DATA_SIZE                  = 32;
  localparam int SB_CNT_WIDTH               = 2;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

endpackage

// File: rtl/regfile_write_scheduler_write_scoreboard.sv
// Per-register outstanding-write counters: saturating issue/retire counting,
// issue back-pressure (full) and read-after-write hazard flags for decode.
module write_scoreboard
  import regfile_write_scheduler_pkg::*;
#(
  parameter int REG_ADDR_W = INSTRUCTION_REGISTER_WIDTH,
  parameter int CNT_W      = SB_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue,
  input  logic [REG_ADDR_W-1:0] issue_reg,
  input  logic                  retire,
  input  logic [REG_ADDR_W-1:0] retire_reg,
  input  logic [REG_ADDR_W-1:0] rs_q,
  input  logic [REG_ADDR_W-1:0] rt_q,
  output logic                  full,
  output logic                  hazard_rs,
  output logic                  hazard_rt
);

  localparam int              NUM_REGS = 2 ** REG_ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_REGS-1:0][CNT_W-1:0] count;
  logic                           issue_ok;

  // Register 0 is hard-wired, so it can never look busy or full.
  assign count[0] = '0;

  assign full      = (count[issue_reg] == CNT_MAX);
  assign issue_ok  = issue && !full && (issue_reg != '0);
  assign hazard_rs = (count[rs_q] != '0);
  assign hazard_rt = (count[rt_q] != '0);

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      logic             inc;
      logic             dec;

      assign inc = issue_ok && (issue_reg == REG_ADDR_W'(gi));
      assign dec = retire && (retire_reg == REG_ADDR_W'(gi));

      // A retire with no matching issue leaves the counter at zero.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else if (inc && !dec) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end else if (dec && !inc && (cnt_reg != '0)) begin
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
      end

      assign count[gi] = cnt_reg;
    end
  endgenerate

endmodule

// File: rtl/regfile_write_scheduler.sv
// Round-robin arbiter sharing the register bank write port between the fast
// (A) and multi-cycle (B) writeback paths, with a registered bank interface.
module regfile_write_scheduler
  import regfile_write_scheduler_pkg::*;
#(
  parameter int REG_ADDR_W = INSTRUCTION_REGISTER_WIDTH,
  parameter int DATA_W     = DATA_SIZE,
  parameter int CNT_W      = SB_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0]     a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0]     b_data,
  output logic                  b_ready,
  input  logic                  sb_issue,
  input  logic [REG_ADDR_W-1:0] sb_issue_reg,
  output logic                  sb_full,
  input  logic [REG_ADDR_W-1:0] rs_q,
  input  logic [REG_ADDR_W-1:0] rt_q,
  output logic                  hazard_rs,
  output logic                  hazard_rt,
  output logic [REG_ADDR_W-1:0] rw,
  output logic [DATA_W-1:0]     bus_rw,
  output logic                  reg_write
);

  grant_e                  last_grant_reg;
  logic                    grant_a;
  logic                    grant_b;
  logic                    xfer;
  logic [REG_ADDR_W-1:0]   sel_reg;
  logic [DATA_W-1:0]       sel_data;

  // Reset gates the grants so no handshake can complete while it is held.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (reset) begin
      if (a_valid && (!b_valid || (last_grant_reg == GRANT_B))) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign xfer     = grant_a || grant_b;
  assign sel_reg  = grant_a ? a_reg  : b_reg;
  assign sel_data = grant_a ? a_data : b_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_reg <= GRANT_B;
      rw             <= '0;
      bus_rw         <= '0;
      reg_write      <= 1'b0;
    end else if (xfer) begin
      last_grant_reg <= grant_a ? GRANT_A : GRANT_B;
      rw             <= sel_reg;
      bus_rw         <= sel_data;
      reg_write      <= (sel_reg != '0);
    end else begin
      reg_write      <= 1'b0;
    end
  end

  write_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .CNT_W      (CNT_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .issue      (sb_issue),
    .issue_reg  (sb_issue_reg),
    .retire     (xfer),
    .retire_reg (sel_reg),
    .rs_q       (rs_q),
    .rt_q       (rt_q),
    .full       (sb_full),
    .hazard_rs  (hazard_rs),
    .hazard_rt  (hazard_rt)
  );

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed plus randomized bench for the write scheduler, checked against a
// cycle-level behavioural model (per-register counts, last winner, bank write).
module tb_regfile_write_scheduler;

  localparam int CNT_MAX = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, sb_issue;
  logic [4:0]  a_reg, b_reg, sb_issue_reg, rs_q, rt_q;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, sb_full, hazard_rs, hazard_rt, reg_write;
  logic [4:0]  rw;
  logic [31:0] bus_rw;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          mcnt [32];
  bit          last_b;
  logic [4:0]  exp_rw;
  logic [31:0] exp_bus;
  bit          exp_we;

  always #5 clk = ~clk;

  regfile_write_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .a_valid      (a_valid),
    .a_reg        (a_reg),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_reg        (b_reg),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .sb_issue     (sb_issue),
    .sb_issue_reg (sb_issue_reg),
    .sb_full      (sb_full),
    .rs_q         (rs_q),
    .rt_q         (rt_q),
    .hazard_rs    (hazard_rs),
    .hazard_rt    (hazard_rt),
    .rw           (rw),
    .bus_rw       (bus_rw),
    .reg_write    (reg_write)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    last_b  = 1'b1;
    exp_rw  = '0;
    exp_bus = '0;
    exp_we  = 1'b0;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next.
  task automatic cycle(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit bv, input logic [4:0] br, input logic [31:0] bd,
                       input bit iss, input logic [4:0] ir,
                       input logic [4:0] rs, input logic [4:0] rt);
    bit ga, gb, full, inc;
    int wreg;
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    sb_issue = iss; sb_issue_reg = ir; rs_q = rs; rt_q = rt;
    #1;
    ga   = av && (!bv || last_b);
    gb   = bv && !ga;
    full = (mcnt[ir] == CNT_MAX);
    check("a_ready", a_ready, ga);
    check("b_ready", b_ready, gb);
    check("sb_full", sb_full, full);
    check("hazard_rs", hazard_rs, mcnt[rs] != 0);
    check("hazard_rt", hazard_rt, mcnt[rt] != 0);
    wreg = 0;
    if (ga || gb) begin
      exp_rw  = ga ? ar : br;
      exp_bus = ga ? ad : bd;
      exp_we  = (exp_rw != 0);
      last_b  = gb;
      wreg    = exp_rw;
    end else begin
      exp_we = 1'b0;
    end
    inc = iss && (ir != 0) && !full;
    if (!(inc && wreg == int'(ir))) begin
      if (inc) mcnt[ir]++;
      if (wreg != 0 && mcnt[wreg] > 0) mcnt[wreg]--;
    end
    @(posedge clk); #1;
    check("rw", rw, exp_rw);
    check("bus_rw", bus_rw, exp_bus);
    check("reg_write", reg_write, exp_we);
    $display("cyc a=%0b/r%0d b=%0b/r%0d rdy=%0b%0b iss=%0b/r%0d -> we=%0b rw=%0d bus=0x%0h",
             av, ar, bv, br, ga, gb, iss, ir, reg_write, rw, bus_rw);
  endtask

  initial begin
    model_reset();
    reset = 1'b0;
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h11;
    b_valid = 1'b0; b_reg = '0; b_data = '0;
    sb_issue = 1'b0; sb_issue_reg = '0; rs_q = 5'd3; rt_q = 5'd4;
    #12;
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_reg_write", reg_write, 1'b0);
    check("rst_rw", rw, 5'd0);
    check("rst_bus_rw", bus_rw, 32'd0);
    check("rst_hazard_rs", hazard_rs, 1'b0);
    check("rst_hazard_rt", hazard_rt, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Contention: expect A,B,A,B
    for (int i = 0; i < 4; i++)
      cycle(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 5'd0, 5'd3, 5'd4);

    // Register 0 is consumed but never written
    cycle(0, 5'd0, 32'h0, 1, 5'd0, 32'hDEAD, 0, 5'd0, 5'd0, 5'd0);
    check("r0_hazard", hazard_rs, 1'b0);

    // Scoreboard fill, ignored fourth issue, then drain
    for (int i = 0; i < 4; i++)
      cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd5, 5'd5, 5'd0);
    for (int i = 0; i < 3; i++)
      cycle(1, 5'd5, 32'h500 + i, 0, 5'd0, 32'h0, 0, 5'd5, 5'd5, 5'd0);
    check("r5_drained", hazard_rs, 1'b0);

    // Simultaneous issue and retire on r7
    cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd7, 5'd0, 5'd7);
    cycle(1, 5'd7, 32'h77, 0, 5'd0, 32'h0, 1, 5'd7, 5'd0, 5'd7);
    cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd7);

    // Mid-operation reset while reg_write is high
    cycle(1, 5'd9, 32'h99, 0, 5'd0, 32'h0, 1, 5'd9, 5'd7, 5'd9);
    reset = 1'b0; a_valid = 1'b1; rs_q = 5'd7; rt_q = 5'd9;
    #1;
    model_reset();
    check("midrst_reg_write", reg_write, 1'b0);
    check("midrst_rw", rw, 5'd0);
    check("midrst_a_ready", a_ready, 1'b0);
    check("midrst_hazard_rs", hazard_rs, 1'b0);
    check("midrst_hazard_rt", hazard_rt, 1'b0);
    @(posedge clk); #1;
    check("midrst_hold_ready", a_ready, 1'b0);
    check("midrst_hold_we", reg_write, 1'b0);
    reset = 1'b1;
    cycle(1, 5'd3, 32'hA1, 1, 5'd4, 32'hB1, 0, 5'd0, 5'd7, 5'd9);

    // Randomized traffic on a small register window to provoke hazards
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
